// File: rtl/sram_stream_reader.sv
// Burst reader: walks len consecutive memory words from a base address and streams them
// out on a valid/ready interface. A 2-entry FIFO with credit-based issue hides the 1-cycle
// memory read latency while sustaining one word per cycle.
module sram_stream_reader #(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned DataDepth = 4096,
  localparam int unsigned AddrWidth = (DataDepth <= 1) ? 1 : $clog2(DataDepth)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] base_addr_i,
  input  logic [AddrWidth:0]   len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic                 mem_we_o,
  output logic [DataWidth-1:0] mem_wr_data_o,
  input  logic [DataWidth-1:0] mem_rd_data_i,
  output logic [DataWidth-1:0] out_data_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] base_q, base_d;
  logic [AddrWidth:0]   len_q, len_d;
  logic [AddrWidth:0]   issued_q, issued_d;
  logic                 inflight_q;
  logic [AddrWidth-1:0] mem_addr_q;
  logic [DataWidth-1:0] fifo_q [2];
  logic                 rd_ptr_q, wr_ptr_q;
  logic [1:0]           count_q, count_d;

  logic                 pop, push, issue;
  logic [1:0]           occupancy;
  logic [AddrWidth-1:0] issue_addr;

  // Credit check: slots already promised (FIFO after this cycle's pop plus read in flight).
  always_comb begin
    pop        = (count_q != 2'd0) && out_ready_i;
    push       = inflight_q;
    occupancy  = count_q - {1'b0, pop} + {1'b0, inflight_q};
    issue      = (state_q == StRun) && (issued_q < len_q) && (occupancy < 2'd2);
    issue_addr = base_q + issued_q[AddrWidth-1:0];
    count_d    = count_q + {1'b0, push} - {1'b0, pop};
  end

  // FSM next state and burst bookkeeping.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    len_d    = len_q;
    issued_d = issued_q;
    if (issue) issued_d = issued_q + {{AddrWidth{1'b0}}, 1'b1};
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          base_d   = base_addr_i;
          len_d    = len_i;
          issued_d = '0;
          state_d  = (len_i == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        // Finish once the last word leaves the FIFO; the pop in this cycle counts.
        if ((issued_q == len_q) && !inflight_q && ((count_q - {1'b0, pop}) == 2'd0)) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, counters and FIFO storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      base_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      inflight_q <= 1'b0;
      mem_addr_q <= '0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      inflight_q <= issue;
      if (issue) mem_addr_q <= issue_addr;
      if (push) begin
        fifo_q[wr_ptr_q] <= mem_rd_data_i;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  // Outputs; the address holds its last issued value when no read is issued.
  always_comb begin
    busy_o        = (state_q != StIdle);
    done_o        = (state_q == StDone);
    mem_addr_o    = issue ? issue_addr : mem_addr_q;
    mem_we_o      = 1'b0;
    mem_wr_data_o = '0;
    out_data_o    = fifo_q[rd_ptr_q];
    out_valid_o   = (count_q != 2'd0);
  end

endmodule

// File: tb/tb_sram_stream_reader.sv
// Bench for sram_stream_reader: a memory model with 1-cycle read latency, directed bursts with
// random backpressure, and an expected-word sequence derived from base/len arithmetic.
module tb_sram_stream_reader;
  localparam int unsigned DW = 8;
  localparam int unsigned DEPTH = 4096;
  localparam int unsigned AW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_in = '0;
  logic [AW:0]   len_in = '0;
  logic          ready = 1'b0;
  logic          busy, done, mem_we, out_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data, mem_rd_data, out_data;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] mem [DEPTH];

  sram_stream_reader #(.DataWidth(DW), .DataDepth(DEPTH)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .start_i       (start),
    .base_addr_i   (base_in),
    .len_i         (len_in),
    .busy_o        (busy),
    .done_o        (done),
    .mem_addr_o    (mem_addr),
    .mem_we_o      (mem_we),
    .mem_wr_data_o (mem_wr_data),
    .mem_rd_data_i (mem_rd_data),
    .out_data_o    (out_data),
    .out_valid_o   (out_valid),
    .out_ready_i   (ready)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory.
  always @(posedge clk) mem_rd_data <= mem[mem_addr];

  function automatic logic [DW-1:0] ref_word(int unsigned a);
    int unsigned w;
    w = (a % DEPTH) & 32'hFF;
    return DW'(w) ^ 8'h5A;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, ":busy"}, 32'(busy), 0);
    chk({tag, ":done"}, 32'(done), 0);
    chk({tag, ":valid"}, 32'(out_valid), 0);
    chk({tag, ":data"}, 32'(out_data), 0);
    chk({tag, ":addr"}, 32'(mem_addr), 0);
    chk({tag, ":we"}, 32'(mem_we), 0);
    chk({tag, ":wdata"}, 32'(mem_wr_data), 0);
  endtask

  // One burst; cyc counts negedges after the start-accepting edge.
  task automatic run_burst(string tag, int unsigned base, int unsigned len, bit rand_ready,
                           bit restart_mid, int abort_after);
    int            idx = 0;
    int            cyc = 1;
    int            first_valid = -1;
    int            off = 0;
    int            last_off = 0;
    int            budget;
    bit            finished = 0;
    bit            prev_hold = 0;
    logic [DW-1:0] prev_data = '0;
    logic [AW-1:0] alt_base;
    @(negedge clk);
    start   = 1'b1;
    base_in = base[AW-1:0];
    len_in  = len[AW:0];
    ready   = 1'b0;
    @(negedge clk);
    start  = 1'b0;
    budget = 20 * int'(len) + 20;
    while (!finished && cyc < budget) begin
      if (restart_mid && cyc == 4) begin
        alt_base = AW'(base + 777);
        start    = 1'b1;
        base_in  = alt_base;
        len_in   = 13'd5;
      end else begin
        start = 1'b0;
      end
      if (abort_after >= 0 && idx == abort_after) begin
        ready = 1'b0;
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs({tag, ":abort"});
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (prev_hold) begin
        chk({tag, ":hold_valid"}, 32'(out_valid), 1);
        chk({tag, ":hold_data"}, 32'(out_data), 32'(prev_data));
      end
      if (out_valid && first_valid < 0) begin
        first_valid = cyc;
        if (!rand_ready) chk({tag, ":latency"}, 32'(cyc), 3);
      end
      ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (done) begin
        chk({tag, ":count"}, 32'(idx), 32'(len));
        chk({tag, ":busy_at_done"}, 32'(busy), 1);
        chk({tag, ":valid_at_done"}, 32'(out_valid), 0);
        if (!rand_ready) chk({tag, ":done_time"}, 32'(cyc), (len == 0) ? 1 : 32'(len + 3));
        finished = 1;
      end else begin
        chk({tag, ":busy"}, 32'(busy), 1);
        if (out_valid && ready) begin
          chk({tag, ":extra_word"}, 32'(idx < int'(len)), 1);
          if (idx < int'(len)) chk({tag, ":data"}, 32'(out_data), 32'(ref_word(base + idx)));
          idx++;
        end
        if (len > 0) begin
          off = (int'(mem_addr) + DEPTH - base) % DEPTH;
          if (cyc == 1) chk({tag, ":first_addr"}, 32'(mem_addr), 32'(base[AW-1:0]));
          else chk({tag, ":addr_window"},
                   32'(off < int'(len) && off >= last_off && off <= idx + 1), 1);
          last_off = off;
        end
      end
      prev_hold = out_valid && !ready;
      prev_data = out_data;
      if (!finished) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!finished) begin
      chk({tag, ":timeout"}, 0, 1);
    end else begin
      @(negedge clk);
      ready = 1'b0;
      #1;
      chk({tag, ":done_pulse"}, 32'(done), 0);
      chk({tag, ":busy_after"}, 32'(busy), 0);
      chk({tag, ":valid_after"}, 32'(out_valid), 0);
    end
  endtask

  initial begin
    for (int a = 0; a < int'(DEPTH); a++) mem[a] = ref_word(a);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_burst("t1", 0, 16, 1'b0, 1'b0, -1);
    run_burst("t2", 4094, 4, 1'b0, 1'b0, -1);
    run_burst("t3", $urandom_range(0, DEPTH - 1), 64, 1'b1, 1'b0, -1);
    run_burst("t4", 5, 0, 1'b0, 1'b0, -1);
    run_burst("t5", 200, 12, 1'b0, 1'b1, -1);
    run_burst("t6a", 300, 20, 1'b1, 1'b0, 5);
    run_burst("t6b", 100, 3, 1'b0, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
